// File: rtl/example_01_sequencer.sv
// Sequencer that walks the example_01 five-state FSM through S0..S4 and back,
// checking its Q feedback after every drive step. It repeats the walk NUM_RUNS
// times per start, then pulses done, or pulses err with a cause code.
module example_01_sequencer #(
    parameter int unsigned NUM_RUNS       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] q_fb,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic [3:0] d_o,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] run_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] EC_NONE    = 2'd0;
    localparam logic [1:0] EC_NOT_S0  = 2'd1;
    localparam logic [1:0] EC_TIMEOUT = 2'd2;
    localparam logic [1:0] EC_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRV_A,
        ST_DRV_D1,
        ST_DRV_ABC,
        ST_DRV_DF,
        ST_WAIT_S0,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [TW-1:0] timer;
    logic [7:0]    runs_left;
    logic          in_step;
    logic          hit;

    // Q value that ends the current step
    function automatic logic [2:0] exp_q(input state_t s);
        case (s)
            ST_DRV_A:   exp_q = 3'b001;
            ST_DRV_D1:  exp_q = 3'b010;
            ST_DRV_ABC: exp_q = 3'b011;
            ST_DRV_DF:  exp_q = 3'b100;
            default:    exp_q = 3'b000;
        endcase
    endfunction

    // Next-state selection: abort beats the expected Q, which beats the timeout
    always_comb begin
        nxt     = state;
        in_step = (state inside {ST_DRV_A, ST_DRV_D1, ST_DRV_ABC, ST_DRV_DF, ST_WAIT_S0});
        hit     = (q_fb == exp_q(state));
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    nxt = (q_fb == 3'b000) ? ST_DRV_A : ST_ERR;
                end
            end
            ST_DRV_A, ST_DRV_D1, ST_DRV_ABC, ST_DRV_DF, ST_WAIT_S0: begin
                if (abort) begin
                    nxt = ST_ERR;
                end else if (hit) begin
                    case (state)
                        ST_DRV_A:   nxt = ST_DRV_D1;
                        ST_DRV_D1:  nxt = ST_DRV_ABC;
                        ST_DRV_ABC: nxt = ST_DRV_DF;
                        ST_DRV_DF:  nxt = ST_WAIT_S0;
                        default:    nxt = (runs_left == 8'd1) ? ST_DONE : ST_DRV_A;
                    endcase
                end else if (timer == TLAST) begin
                    nxt = ST_ERR;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // State, counters, error code and Moore outputs decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            runs_left <= '0;
            run_cnt   <= '0;
            err_code  <= EC_NONE;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            c_o       <= 1'b0;
            d_o       <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= nxt;

            if (nxt != state || !in_step) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            if (state == ST_IDLE && start && !abort) begin
                runs_left <= 8'(NUM_RUNS);
                err_code  <= (q_fb == 3'b000) ? EC_NONE : EC_NOT_S0;
            end else if (in_step && nxt == ST_ERR) begin
                err_code <= abort ? EC_ABORT : EC_TIMEOUT;
            end

            if (state == ST_WAIT_S0 && hit && !abort) begin
                run_cnt   <= run_cnt + 8'd1;
                runs_left <= runs_left - 8'd1;
            end

            a_o  <= (nxt inside {ST_DRV_A, ST_DRV_ABC});
            b_o  <= (nxt == ST_DRV_ABC);
            c_o  <= (nxt == ST_DRV_ABC);
            d_o  <= (nxt == ST_DRV_D1) ? 4'b0001 :
                    (nxt == ST_DRV_DF) ? 4'b1111 : 4'b0000;
            busy <= (nxt inside {ST_DRV_A, ST_DRV_D1, ST_DRV_ABC, ST_DRV_DF, ST_WAIT_S0});
            done <= (nxt == ST_DONE);
            err  <= (nxt == ST_ERR);
        end
    end

endmodule

// File: tb/tb_example_01_sequencer.sv
// Directed bench for example_01_sequencer with a behavioural example_01 FSM
// on each instance's feedback path and an override to force Q values.
module tb_example_01_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic mrst;

    always #5 clk = ~clk;

    // instance with one run per start
    logic       start1, abort1;
    logic [2:0] q1, m1, ovr1_val;
    logic       ovr1_en;
    logic       a1, b1, c1, busy1, done1, err1;
    logic [3:0] d1;
    logic [1:0] ec1;
    logic [7:0] rc1;

    // instance with three runs per start
    logic       start3, abort3;
    logic [2:0] q3, m3;
    logic       a3, b3, c3, busy3, done3, err3;
    logic [3:0] d3;
    logic [1:0] ec3;
    logic [7:0] rc3;

    assign q1 = ovr1_en ? ovr1_val : m1;
    assign q3 = m3;

    example_01_sequencer #(.NUM_RUNS(1), .TIMEOUT_CYCLES(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .q_fb(q1),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .busy(busy1), .done(done1),
        .err(err1), .err_code(ec1), .run_cnt(rc1)
    );

    example_01_sequencer #(.NUM_RUNS(3), .TIMEOUT_CYCLES(16)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .q_fb(q3),
        .a_o(a3), .b_o(b3), .c_o(c3), .d_o(d3), .busy(busy3), .done(done3),
        .err(err3), .err_code(ec3), .run_cnt(rc3)
    );

    // behavioural example_01: S0-A->S1-D0001->S2-ABC->S3-D1111->S4->S0
    always_ff @(posedge clk or posedge mrst) begin
        if (mrst) m1 <= 3'd0;
        else case (m1)
            3'd0: if (a1) m1 <= 3'd1;
            3'd1: if (d1 == 4'b0001) m1 <= 3'd2;
            3'd2: if (a1 && b1 && c1) m1 <= 3'd3;
            3'd3: if (d1 == 4'b1111) m1 <= 3'd4;
            default: m1 <= 3'd0;
        endcase
    end

    always_ff @(posedge clk or posedge mrst) begin
        if (mrst) m3 <= 3'd0;
        else case (m3)
            3'd0: if (a3) m3 <= 3'd1;
            3'd1: if (d3 == 4'b0001) m3 <= 3'd2;
            3'd2: if (a3 && b3 && c3) m3 <= 3'd3;
            3'd3: if (d3 == 4'b1111) m3 <= 3'd4;
            default: m3 <= 3'd0;
        endcase
    end

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] t1_exp [11];

    initial begin
        // {a,b,c,d[3:0],busy,done} after each edge of one run
        t1_exp = '{9'b1_0_0_0000_1_0, 9'b1_0_0_0000_1_0,
                   9'b0_0_0_0001_1_0, 9'b0_0_0_0001_1_0,
                   9'b1_1_1_0000_1_0, 9'b1_1_1_0000_1_0,
                   9'b0_0_0_1111_1_0, 9'b0_0_0_1111_1_0,
                   9'b0_0_0_0000_1_0, 9'b0_0_0_0000_0_1,
                   9'b0_0_0_0000_0_0};
        rst = 1'b1; mrst = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; ovr1_en = 1'b0; ovr1_val = 3'b000;
        start3 = 1'b0; abort3 = 1'b0;
        #1;
        chk("rst_outs1", {a1, b1, c1, d1, busy1, done1, err1}, 10'd0);
        chk("rst_cnt_ec1", {rc1, ec1}, 10'd0);
        chk("rst_outs3", {a3, b3, c3, d3, busy3, done3, err3}, 10'd0);
        tick(); tick();
        rst = 1'b0; mrst = 1'b0;
        tick();
        chk("idle_outs1", {a1, b1, c1, d1, busy1, done1, err1}, 10'd0);

        // T1: single run
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t1_e0", {a1, b1, c1, d1, busy1, done1}, 32'(t1_exp[0]));
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("t1_e%0d", i), {a1, b1, c1, d1, busy1, done1}, 32'(t1_exp[i]));
            if (i == 9) chk("t1_err", err1, 0);
        end
        chk("t1_run_cnt", rc1, 1);
        chk("t1_err_code", ec1, 0);

        // T2: three runs back to back
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("t2_e0", {busy3, done3}, 2'b10);
        for (int i = 1; i <= 27; i++) begin
            tick();
            chk($sformatf("t2_e%0d", i), {busy3, done3}, (i <= 26) ? 2'b10 : 2'b01);
        end
        chk("t2_run_cnt", rc3, 3);
        chk("t2_err", err3, 0);
        tick();
        chk("t2_idle", {busy3, done3}, 0);

        // T3: FSM not at S0 when start arrives
        ovr1_val = 3'b010; ovr1_en = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t3_err", {err1, ec1, a1, busy1}, 5'b1_01_0_0);
        tick();
        chk("t3_after", {err1, ec1, a1, busy1}, 5'b0_01_0_0);
        ovr1_en = 1'b0;

        // T4: Q stuck at 001 after DRV_D1 entry
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick();
        chk("t4_d1_entry", {err1, d1}, 5'b0_0001);
        ovr1_val = 3'b001; ovr1_en = 1'b1;
        for (int i = 3; i <= 17; i++) tick();
        chk("t4_e17", {err1, d1, busy1}, 6'b0_0001_1);
        tick();
        chk("t4_timeout", {err1, ec1, d1, busy1}, 8'b1_10_0000_0);
        ovr1_en = 1'b0;
        mrst = 1'b1; #1 mrst = 1'b0;
        tick();
        chk("t4_after", {err1, ec1, rc1}, {1'b0, 2'd2, 8'd1});

        // T5: abort during DRV_ABC
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        chk("t5_abc", {a1, b1, c1, d1}, 7'b111_0000);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        chk("t5_abort", {err1, ec1, a1, b1, c1, d1, busy1}, 11'b1_11_000_0000_0);
        chk("t5_run_cnt", rc1, 1);
        mrst = 1'b1; #1 mrst = 1'b0;
        tick();
        chk("t5_hold_ec", {err1, ec1}, 3'b0_11);

        // T6: asynchronous reset mid DRV_DF, then a fresh run
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= 6; i++) tick();
        chk("t6_df", d1, 4'b1111);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_outs", {a1, b1, c1, d1, busy1, done1, err1}, 10'd0);
        chk("t6_rst_cnt", {rc1, ec1, rc3}, 18'd0);
        #2 rst = 1'b0;
        mrst = 1'b1; #1 mrst = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        chk("t6_done", {done1, err1, rc1}, {1'b1, 1'b0, 8'd1});
        tick();
        chk("t6_idle", {done1, busy1}, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
